framebuffer_plot_writer: RTL and testbench
==========================================

Name: framebuffer_plot_writer

Overview:
- Write-side consumer of the pixel plot stream (X, Y, colour, plot strobe) produced by the screen loaders and sprite drawers.
- Converts each accepted plot into a linear framebuffer write: address = 320*Y + X.
- Drives the write port of the 320x240, 3-bit-colour framebuffer RAM that the VGA scan-out reads.
- Provides a full-screen clear engine and a 4-entry plot buffer so plots arriving during a clear are not lost.

Parameters:
- SCREEN_W, 320, pixels per row
- SCREEN_H, 240, rows per frame
- BG_COLOUR, 3'b000, colour written by a clear
- FIFO_DEPTH, 4, plot buffer entries (power of two)

Ports:
- iClock  in  1  system clock, all logic on rising edge
- iResetn  in  1  asynchronous active-low reset
- iX  in  11  plot X coordinate
- iY  in  10  plot Y coordinate
- iColour  in  3  plot colour
- iPlot  in  1  plot strobe; one plot per cycle high
- iClear  in  1  clear request, sampled per cycle
- oAddr  out  17  framebuffer write address
- oData  out  3  framebuffer write data
- oWren  out  1  framebuffer write enable
- oBusy  out  1  high while clearing or FIFO non-empty
- oClearDone  out  1  one-cycle pulse after last clear write
- oDropCount  out  8  saturating count of plots dropped on FIFO full
- oOobCount  out  8  saturating count of out-of-range plots

Behaviour:
- Reset, asynchronous: all outputs 0; FIFO empty; state IDLE; counters 0. Reset mid-clear aborts immediately; RAM contents are left as-is.
- Input stage, each edge with iPlot=1:
  - X>=SCREEN_W or Y>=SCREEN_H: oOobCount increments, saturating at 255; nothing is pushed.
  - Otherwise, FIFO full and no pop this cycle: oDropCount increments, saturating at 255; plot discarded.
  - Otherwise the plot is pushed. Push and pop in the same cycle are allowed, including when full.
- States:
  - IDLE: iClear=1 goes to CLEAR with the clear counter at 0. Clear has priority over a FIFO pop in the same cycle. Otherwise, if the FIFO is non-empty, pop one entry and register oAddr=Y*320+X, oData=colour, oWren=1.
  - CLEAR: each cycle registers oAddr=counter, oData=BG_COLOUR, oWren=1, then counter+1. On the cycle that registers address 76799, the next edge moves to IDLE and raises oClearDone for exactly one cycle. iClear is ignored in CLEAR. No FIFO pops occur in CLEAR; pushes continue.
- Latency: plot sampled at edge E0 into an empty FIFO in IDLE appears as oWren=1 after edge E1 (2 edges). Steady-state throughput is 1 write per cycle.
- oWren is low in any cycle with no registered write; oAddr and oData hold their last value.
- Address arithmetic: Y*320 is formed as (Y<<8)+(Y<<6), then +X, with a 17-bit result. Max 76799 (0x12BFF); no overflow possible after the range check.
- Clear duration: exactly 76800 consecutive oWren cycles. Buffered plots drain after the clear, so they overwrite the background.
- oBusy = (state==CLEAR) | FIFO non-empty, combinational.

Decomposition:
- Shared package fb_pkg holds:
  - SCREEN_W, SCREEN_H
  - FB_DEPTH=76800, FB_AW=17
  - COLOUR_W=3, X_W=11, Y_W=10
  - State encoding {IDLE, CLEAR}
- One sub-module, plot_fifo: synchronous FIFO, parameterised width and depth, with push/pop/full/empty and same-cycle push+pop when full. The entry is {X, Y, colour}, 24 bits.
- Top holds the range check, counters, FSM and address multiply.

Test Plan:
- Reset, then single plot X=5, Y=2, colour 3'b110 -> two edges later one cycle with oWren=1, oAddr=645, oData=6; oBusy returns to 0.
- Back-to-back plots, 10 cycles, (x, 0) for x=0..9 -> 10 consecutive oWren cycles, oAddr 0..9; no drops.
- Out-of-range plots (320,0), (0,240), (2047,1023) -> no oWren; oOobCount=3; oDropCount=0.
- iClear pulse in IDLE:
  - 76800 consecutive writes, oAddr 0..76799, oData=BG_COLOUR.
  - oClearDone high exactly 1 cycle after the last write.
  - A second iClear mid-clear is ignored.
- 6 plots issued during clear, FIFO_DEPTH=4 -> oDropCount=2; the 4 buffered plots are written in order immediately after oClearDone.
- iResetn low at clear address 1000 -> oWren=0 asynchronously. After release: IDLE, counters 0, and a new iClear restarts at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, widths, state encoding and address helper
package fb_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int FB_DEPTH = 76800;
    localparam int FB_AW    = 17;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fbState_t;

    // Y*320 built from shifts so no multiplier is needed.
    function automatic logic [FB_AW-1:0] pixelAddr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        logic [FB_AW-1:0] yWide;
        yWide = FB_AW'(y);
        return (yWide << 8) + (yWide << 6) + FB_AW'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - synchronous FIFO with same-cycle push and pop allowed when full
module plot_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             iClock,
    input  logic             iResetn,
    input  logic             iPush,
    input  logic             iPop,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData,
    output logic             oFull,
    output logic             oEmpty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPop;
    logic             doPush;

    assign oEmpty = (count == '0);
    assign oFull  = (count == FULL_COUNT);
    assign oData  = mem[rdPtr];
    assign doPop  = iPop && !oEmpty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign doPush = iPush && (!oFull || doPop);

    always_ff @(posedge iClock) begin
        if (doPush) begin
            mem[wrPtr] <= iData;
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (doPush && !doPop) begin
                count <= count + (AW+1)'(1);
            end else if (doPop && !doPush) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/framebuffer_plot_writer.sv
// rtl/framebuffer_plot_writer.sv - plot stream to framebuffer write port with clear engine
module framebuffer_plot_writer
    import fb_pkg::*;
#(
    parameter logic [COLOUR_W-1:0] BG_COLOUR  = '0,
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iPlot,
    input  logic                iClear,
    output logic [FB_AW-1:0]    oAddr,
    output logic [COLOUR_W-1:0] oData,
    output logic                oWren,
    output logic                oBusy,
    output logic                oClearDone,
    output logic [7:0]          oDropCount,
    output logic [7:0]          oOobCount
);

    localparam int ENTRY_W = X_W + Y_W + COLOUR_W;

    fbState_t            state;
    logic [FB_AW-1:0]    clearCnt;
    logic [ENTRY_W-1:0]  headEntry;
    logic [X_W-1:0]      headX;
    logic [Y_W-1:0]      headY;
    logic [COLOUR_W-1:0] headColour;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                fifoPop;
    logic                fifoPush;
    logic                inRange;
    logic                oobHit;
    logic                dropHit;

    assign inRange  = (iX < X_W'(SCREEN_W)) && (iY < Y_W'(SCREEN_H));
    assign fifoPop  = (state == IDLE) && !iClear && !fifoEmpty;
    assign fifoPush = iPlot && inRange && (!fifoFull || fifoPop);
    assign oobHit   = iPlot && !inRange;
    assign dropHit  = iPlot && inRange && fifoFull && !fifoPop;
    assign oBusy    = (state == CLEAR) || !fifoEmpty;

    assign {headX, headY, headColour} = headEntry;

    plot_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_plot_fifo (
        .iClock  (iClock),
        .iResetn (iResetn),
        .iPush   (fifoPush),
        .iPop    (fifoPop),
        .iData   ({iX, iY, iColour}),
        .oData   (headEntry),
        .oFull   (fifoFull),
        .oEmpty  (fifoEmpty)
    );

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oOobCount  <= '0;
            oDropCount <= '0;
        end else begin
            if (oobHit && (oOobCount != 8'hFF)) begin
                oOobCount <= oOobCount + 8'd1;
            end
            if (dropHit && (oDropCount != 8'hFF)) begin
                oDropCount <= oDropCount + 8'd1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state      <= IDLE;
            clearCnt   <= '0;
            oAddr      <= '0;
            oData      <= '0;
            oWren      <= 1'b0;
            oClearDone <= 1'b0;
        end else begin
            oWren      <= 1'b0;
            oClearDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iClear) begin
                        state    <= CLEAR;
                        clearCnt <= '0;
                    end else if (fifoPop) begin
                        oAddr <= pixelAddr(headX, headY);
                        oData <= headColour;
                        oWren <= 1'b1;
                    end
                end
                CLEAR: begin
                    // One extra cycle after the last write raises the done pulse.
                    if (clearCnt == FB_AW'(FB_DEPTH)) begin
                        state      <= IDLE;
                        oClearDone <= 1'b1;
                    end else begin
                        oAddr    <= clearCnt;
                        oData    <= BG_COLOUR;
                        oWren    <= 1'b1;
                        clearCnt <= clearCnt + FB_AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_plot_writer.sv
// tb/tb_framebuffer_plot_writer.sv - randomized self-checking bench against a queue reference model
module tb_framebuffer_plot_writer;

    logic        iClock = 1'b0;
    logic        iResetn;
    logic [10:0] iX;
    logic [9:0]  iY;
    logic [2:0]  iColour;
    logic        iPlot;
    logic        iClear;
    logic [16:0] oAddr;
    logic [2:0]  oData;
    logic        oWren;
    logic        oBusy;
    logic        oClearDone;
    logic [7:0]  oDropCount;
    logic [7:0]  oOobCount;

    int checks   = 0;
    int failures = 0;
    int expQ[$];
    int modelOob;
    int sbErr;
    int nWrites;
    int nPushed;
    int clrErr;

    framebuffer_plot_writer dut (
        .iClock     (iClock),
        .iResetn    (iResetn),
        .iX         (iX),
        .iY         (iY),
        .iColour    (iColour),
        .iPlot      (iPlot),
        .iClear     (iClear),
        .oAddr      (oAddr),
        .oData      (oData),
        .oWren      (oWren),
        .oBusy      (oBusy),
        .oClearDone (oClearDone),
        .oDropCount (oDropCount),
        .oOobCount  (oOobCount)
    );

    always #5 iClock = ~iClock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    function automatic int refWord(input int x, input int y, input int c);
        return (y * 320 + x) * 8 + c;
    endfunction

    function automatic int obsWord();
        return int'(oAddr) * 8 + int'(oData);
    endfunction

    initial begin
        int x;
        int y;
        int c;
        iResetn = 1'b0;
        iX = '0; iY = '0; iColour = '0; iPlot = 1'b0; iClear = 1'b0;
        repeat (3) tick();
        checkEq("rst_wren", oWren, 0);
        checkEq("rst_addr", oAddr, 0);
        checkEq("rst_busy", oBusy, 0);
        checkEq("rst_done", oClearDone, 0);
        checkEq("rst_drop", oDropCount, 0);
        checkEq("rst_oob", oOobCount, 0);
        iResetn = 1'b1;
        tick();

        // single plot latency
        iX = 11'd5; iY = 10'd2; iColour = 3'b110; iPlot = 1'b1;
        tick();
        iPlot = 1'b0;
        checkEq("single_e0_wren", oWren, 0);
        checkEq("single_e0_busy", oBusy, 1);
        tick();
        checkEq("single_wren", oWren, 1);
        checkEq("single_addr", oAddr, 645);
        checkEq("single_data", oData, 6);
        checkEq("single_busy", oBusy, 0);
        tick();
        checkEq("single_after_wren", oWren, 0);
        checkEq("single_hold_addr", oAddr, 645);

        // back-to-back row plots
        for (int i = 0; i < 10; i++) begin
            iX = 11'(i); iY = '0; iColour = 3'(i); iPlot = 1'b1;
            tick();
            if (i >= 1) begin
                checkEq("b2b_wren", oWren, 1);
                checkEq("b2b_addr", oAddr, 32'(i - 1));
            end
        end
        iPlot = 1'b0;
        tick();
        checkEq("b2b_last_wren", oWren, 1);
        checkEq("b2b_last_addr", oAddr, 9);
        tick();
        checkEq("b2b_drop", oDropCount, 0);

        // out-of-range plots
        for (int i = 0; i < 3; i++) begin
            iX = (i == 0) ? 11'd320 : (i == 1) ? 11'd0 : 11'd2047;
            iY = (i == 0) ? 10'd0 : (i == 1) ? 10'd240 : 10'd1023;
            iPlot = 1'b1;
            tick();
            checkEq("oob_wren", oWren, 0);
        end
        iPlot = 1'b0;
        tick();
        checkEq("oob_wren_tail", oWren, 0);
        checkEq("oob_count", oOobCount, 3);
        checkEq("oob_drop", oDropCount, 0);
        modelOob = 3;

        // randomized plot stream, in-range plots must come out in order
        sbErr = 0; nWrites = 0; nPushed = 0;
        for (int i = 0; i < 300; i++) begin
            if (oWren) begin
                nWrites++;
                if (expQ.size() == 0) sbErr++;
                else if (obsWord() != expQ.pop_front()) sbErr++;
            end
            iPlot = ($urandom_range(0, 9) < 7);
            x = $urandom_range(0, 399);
            y = $urandom_range(0, 299);
            c = $urandom_range(0, 7);
            iX = 11'(x); iY = 10'(y); iColour = 3'(c);
            if (iPlot) begin
                if (x < 320 && y < 240) begin
                    expQ.push_back(refWord(x, y, c));
                    nPushed++;
                end else if (modelOob < 255) begin
                    modelOob++;
                end
            end
            tick();
        end
        iPlot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (oWren) begin
                nWrites++;
                if (expQ.size() == 0) sbErr++;
                else if (obsWord() != expQ.pop_front()) sbErr++;
            end
            tick();
        end
        checkEq("rand_sb_err", sbErr, 0);
        checkEq("rand_pending", expQ.size(), 0);
        checkEq("rand_writes", nWrites, nPushed);
        checkEq("rand_oob", oOobCount, modelOob);
        checkEq("rand_drop", oDropCount, 0);
        checkEq("rand_busy", oBusy, 0);

        // full clear with an ignored second request and plots buffered meanwhile
        expQ.delete();
        clrErr = 0;
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        checkEq("clr_start_wren", oWren, 0);
        checkEq("clr_start_busy", oBusy, 1);
        for (int n = 0; n < 76800; n++) begin
            tick();
            if (!oWren || oAddr != 17'(n) || oData != 3'b000 || oClearDone) clrErr++;
            if (n == 50) checkEq("clr_busy", oBusy, 1);
            iClear = (n == 100);
            iPlot  = (n >= 200 && n < 206);
            if (iPlot) begin
                x = $urandom_range(0, 319);
                y = $urandom_range(0, 239);
                c = $urandom_range(0, 7);
                iX = 11'(x); iY = 10'(y); iColour = 3'(c);
                if (n < 204) expQ.push_back(refWord(x, y, c));
            end
        end
        iPlot = 1'b0;
        iClear = 1'b0;
        checkEq("clr_write_err", clrErr, 0);
        tick();
        checkEq("clr_done", oClearDone, 1);
        checkEq("clr_done_wren", oWren, 0);
        checkEq("clr_drop", oDropCount, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkEq("drain_wren", oWren, 1);
            checkEq("drain_word", obsWord(), (expQ.size() > 0) ? expQ.pop_front() : -1);
            checkEq("drain_done_low", oClearDone, 0);
        end
        tick();
        checkEq("drain_end_wren", oWren, 0);
        checkEq("drain_end_busy", oBusy, 0);

        // reset in the middle of a clear
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        for (int n = 0; n <= 1000; n++) tick();
        checkEq("pre_rst_addr", oAddr, 1000);
        checkEq("pre_rst_wren", oWren, 1);
        #2;
        iResetn = 1'b0;
        #1;
        checkEq("arst_wren", oWren, 0);
        checkEq("arst_addr", oAddr, 0);
        checkEq("arst_busy", oBusy, 0);
        checkEq("arst_drop", oDropCount, 0);
        checkEq("arst_oob", oOobCount, 0);
        tick();
        iResetn = 1'b1;
        tick();
        checkEq("post_rst_wren", oWren, 0);
        checkEq("post_rst_busy", oBusy, 0);
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        tick();
        checkEq("restart_wren", oWren, 1);
        checkEq("restart_addr0", oAddr, 0);
        tick();
        checkEq("restart_addr1", oAddr, 1);
        iResetn = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
